noc_output_arbiter: RTL
=======================

# noc_output_arbiter

Credit-based, wormhole-locked round-robin arbiter that shares one router output link among `N_PORTS` input ports. It sits between the router's input buffers and an output link, and drives the output link's `enable_o`/`data_o`. It tracks downstream buffer space with a credit counter fed by `credit_i`, and returns a per-input `credit_o` pulse for every flit it accepts.

## Interface
- `N_PORTS`, 4, number of requesting input ports (2..8)
- `DATA_W`, 16, flit width; bit `DATA_W-1` is the tail marker
- `CREDIT_MAX`, 4, downstream buffer depth in flits (1..15)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  N_PORTS  per-port flit valid
- `data_i`  in  N_PORTS*DATA_W  per-port flits; port k occupies bits [k*DATA_W +: DATA_W]
- `credit_i`  in  1  one-cycle pulse from downstream: one buffer slot freed
- `enable_o`  out  1  flit valid on the output link
- `data_o`  out  DATA_W  output flit
- `credit_o`  out  N_PORTS  one-hot accept pulse; port k's flit is consumed this cycle
- `err_o`  out  1  sticky credit-overflow error

## Operation
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- State machine:
  - IDLE: no packet is open.
  - LOCKED: `owner` register holds the port whose packet is in flight.
- Credit counter `cnt`:
  - Width $clog2(CREDIT_MAX+1). Resets to `CREDIT_MAX`.
  - Flit sent: -1. `credit_i`: +1. Both in the same cycle: unchanged.
  - `credit_i` with `cnt==CREDIT_MAX` and no send: `cnt` holds and `err_o` sets. `err_o` clears only on `rst`.
- Send permitted only when `cnt>0`.
- IDLE:
  - Search `valid_i` round-robin, starting at pointer `rr` (reset 0) and wrapping modulo N_PORTS.
  - The first valid port g wins when `cnt>0`.
  - If g's flit has no tail bit, go to LOCKED with `owner=g`.
  - If the flit has the tail bit (single-flit packet), stay IDLE and set `rr=(g+1)%N_PORTS`.
- LOCKED:
  - Only `owner` is eligible. Other ports are never granted, even if the owner is idle (bubble).
  - An owner flit with the tail bit set is sent, then the FSM returns to IDLE and sets `rr=(owner+1)%N_PORTS`.
- Accept cycle t for port g:
  - `credit_o[g]=1` combinationally in cycle t; all other bits 0; at most one bit high.
  - The flit is registered and appears on `data_o` with `enable_o=1` in cycle t+1.
- No accept in a cycle: next cycle `enable_o=0` and `data_o` holds its last value.
- `rst` forces `credit_o` to 0 in the same cycle, regardless of inputs.

## Timing
- Reset values: `enable_o=0`, `data_o=0`, `credit_o=0`, `err_o=0`, `cnt=CREDIT_MAX`, FSM=IDLE, `rr=0`, `owner=0`.
- Latency: input flit accepted in cycle t, on the output in t+1. Throughput is one flit per cycle while credits last.
- Credits:
  - A `credit_i` pulse in cycle t is usable for an accept in t+1, not in t.
  - Exception: a send and a `credit_i` in the same cycle are legal and net zero.
- With `cnt==0`, no `credit_o` is asserted. Requesters hold `valid_i`/`data_i` until their `credit_o` bit is seen.
- Requester changes are sampled only on edges where its `credit_o` was high.
- Reset mid-packet:
  - Lock, pointer and credits return to reset values on the next edge.
  - The partially sent packet is abandoned; no tail is synthesized.
- Pointer wrap: owner N_PORTS-1 completing a packet gives `rr=0`.

## Test plan
- **Reset defaults:** assert `rst` 2 cycles with all `valid_i=1` -> `credit_o=0`, `enable_o=0`, `data_o=0`, `err_o=0` throughout. Then 4 flits are accepted back-to-back (CREDIT_MAX=4) and the 5th stalls.
- **Round robin:** ports 0..3 each continuously offer single-flit packets with tail bit set (0x8000|k), credits refilled every cycle -> `credit_o` sequence 0001,0010,0100,1000,0001. `data_o` follows one cycle later: 0x8000,0x8001,0x8002,0x8003.
- **Wormhole lock:** port 1 sends 0x0011,0x0012,0x8013 while port 2 is valid; port 1 drops valid for one cycle mid-packet -> port 2 is never granted until 0x8013 leaves. There is a one-cycle `enable_o=0` bubble, then port 2 is granted next.
- **Credit exhaustion:** CREDIT_MAX=4, no `credit_i`, port 0 streams -> exactly 4 accepts, `cnt=0`, stall. A single `credit_i` pulse in cycle t produces exactly one accept in t+1. Simultaneous send+`credit_i` at `cnt=2` leaves `cnt=2`.
- **Overflow:** `credit_i` pulsed at `cnt=CREDIT_MAX` with no traffic -> `err_o=1` from the next cycle and stays high until `rst`, with `cnt` remaining 4.
- **Reset mid-packet:** port 3 locked after head 0x0030; `rst` pulsed one cycle -> FSM IDLE, `rr=0`. With ports 0 and 3 valid afterwards, port 0 is granted first.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Credit-based, wormhole-locked round-robin arbiter sharing one router output
// link among N_PORTS input ports; accepted flits appear on the link one cycle later.
module noc_output_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 16,
  parameter int CREDIT_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        valid_i,
  input  logic [N_PORTS*DATA_W-1:0] data_i,
  input  logic                      credit_i,
  output logic                      enable_o,
  output logic [DATA_W-1:0]         data_o,
  output logic [N_PORTS-1:0]        credit_o,
  output logic                      err_o
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(CREDIT_MAX + 1);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CREDIT_MAX);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                enable_q, enable_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                found;
  logic [PTR_W-1:0]    sel;
  logic [PTR_W-1:0]    idx;
  logic [PTR_W-1:0]    sel_next;
  logic                send;
  logic [DATA_W-1:0]   flit;
  logic                tail;

  // While IDLE the first valid port at or after rr_q wins; a locked packet
  // restricts eligibility to its owner, even when the owner has a bubble.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    idx   = rr_q;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = PTR_W'((int'(rr_q) + i) % N_PORTS);
      if (!found && valid_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    if (state_q == LOCKED) begin
      found = valid_i[owner_q];
      sel   = owner_q;
    end
  end

  assign send     = found && (cnt_q != '0) && !rst;
  assign flit     = data_i[int'(sel)*DATA_W +: DATA_W];
  assign tail     = flit[DATA_W-1];
  assign sel_next = (sel == LAST_PORT) ? '0 : sel + PTR_W'(1);
  assign credit_o = send ? (N_PORTS'(1) << sel) : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    enable_d = send;
    data_d   = send ? flit : data_q;

    if (send) begin
      if (tail) begin
        state_d = IDLE;
        rr_d    = sel_next;
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end

    // A credit returned while already full is a downstream protocol error.
    if (send && !credit_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!send && credit_i) begin
      if (cnt_q == CNT_FULL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= CNT_FULL;
      err_q    <= 1'b0;
      enable_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      enable_q <= enable_d;
      data_q   <= data_d;
    end
  end

  assign enable_o = enable_q;
  assign data_o   = data_q;
  assign err_o    = err_q;

  a_grant_onehot : assert property (@(posedge clk) $onehot0(credit_o));
  a_cnt_range    : assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);

endmodule
